// File: rtl/threshold_engine_if.sv
// RAM port-2 bus between the threshold engine (master) and the dual-port RAM (slave).
interface threshold_engine_if #(
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 20
) ();

  logic                  RAM_ren;
  logic                  RAM_wen;
  logic [BYTE_WIDTH-1:0] RAM_in;
  logic [ADDR_WIDTH-1:0] RAM_addr;
  logic [BYTE_WIDTH-1:0] RAM_out;

  modport master (
    output RAM_ren,
    output RAM_wen,
    output RAM_in,
    output RAM_addr,
    input  RAM_out
  );

  modport slave (
    input  RAM_ren,
    input  RAM_wen,
    input  RAM_in,
    input  RAM_addr,
    output RAM_out
  );

endinterface

// File: rtl/threshold_engine.sv
// Multi-mode threshold stage: walks the BMP pixel array in raster order, reads the gray byte of
// each pixel, writes the thresholded value to every channel byte and counts foreground pixels.
module threshold_engine #(
  parameter int unsigned BYTE_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned HEADER_SIZE = 54,
  parameter int unsigned IMG_WIDTH   = 512,
  parameter int unsigned IMG_HEIGHT  = 512,
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned CNT_WIDTH   = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  gray_done,
  input  logic [1:0]            mode,
  input  logic [BYTE_WIDTH-1:0] threshold,
  threshold_engine_if.master    ram,
  output logic [CNT_WIDTH-1:0]  fg_count,
  output logic                  done
);

  // Row pitch in bytes, padded to a multiple of four.
  localparam int unsigned STRIDE = ((IMG_WIDTH * CHANNELS + 3) / 4) * 4;
  localparam int unsigned XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [ADDR_WIDTH-1:0] HdrAddr    = ADDR_WIDTH'(HEADER_SIZE);
  localparam logic [ADDR_WIDTH-1:0] StrideAddr = ADDR_WIDTH'(STRIDE);
  localparam logic [ADDR_WIDTH-1:0] ChAddr     = ADDR_WIDTH'(CHANNELS);
  localparam logic [XW-1:0]         XLast      = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]         YLast      = YW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0]         CLast      = CW'(CHANNELS - 1);
  localparam logic [BYTE_WIDTH-1:0] PixMax     = '1;
  localparam logic [CNT_WIDTH-1:0]  CntMax     = '1;

  typedef enum logic [2:0] {StIdle, StRd, StLat, StWr, StDone} state_e;

  state_e                state_q;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [CW-1:0]         c_q;
  logic [ADDR_WIDTH-1:0] row_base_q;
  logic [ADDR_WIDTH-1:0] pix_base_q;
  logic [1:0]            mode_q;
  logic [BYTE_WIDTH-1:0] thr_q;
  logic                  ren_q;
  logic                  wen_q;
  logic [BYTE_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  fg_q;
  logic                  done_q;
  logic                  last_pix;
  logic                  row_end;

  assign ram.RAM_ren  = ren_q;
  assign ram.RAM_wen  = wen_q;
  assign ram.RAM_in   = wdata_q;
  assign ram.RAM_addr = addr_q;
  assign fg_count     = fg_q;
  assign done         = done_q;

  assign row_end  = (x_q == XLast);
  assign last_pix = row_end && (y_q == YLast);

  function automatic logic [BYTE_WIDTH-1:0] apply_mode(input logic [1:0]            m,
                                                       input logic [BYTE_WIDTH-1:0] p,
                                                       input logic [BYTE_WIDTH-1:0] t);
    logic above;
    above = (p > t);
    case (m)
      2'd0:    return above ? PixMax : '0;
      2'd1:    return above ? '0 : PixMax;
      2'd2:    return above ? t : p;
      default: return above ? p : '0;
    endcase
  endfunction

  // Pixel-walk FSM; every bus output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      c_q        <= '0;
      row_base_q <= '0;
      pix_base_q <= '0;
      mode_q     <= '0;
      thr_q      <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      addr_q     <= '0;
      fg_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && gray_done) begin
            mode_q     <= mode;
            thr_q      <= threshold;
            fg_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= HdrAddr;
            pix_base_q <= HdrAddr;
            ren_q      <= 1'b1;
            addr_q     <= HdrAddr;
            state_q    <= StRd;
          end
        end

        StRd: begin
          ren_q   <= 1'b0;
          addr_q  <= '0;
          state_q <= in_valid ? StLat : StIdle;
        end

        StLat: begin
          if (!in_valid) begin
            state_q <= StIdle;
          end else begin
            if ((ram.RAM_out > thr_q) && (fg_q != CntMax)) begin
              fg_q <= fg_q + CNT_WIDTH'(1);
            end
            wdata_q <= apply_mode(mode_q, ram.RAM_out, thr_q);
            wen_q   <= 1'b1;
            addr_q  <= pix_base_q;
            c_q     <= '0;
            state_q <= StWr;
          end
        end

        StWr: begin
          if (!in_valid) begin
            // Abort leaves the current pixel partially written.
            wen_q   <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
            state_q <= StIdle;
          end else if (c_q != CLast) begin
            c_q    <= c_q + CW'(1);
            addr_q <= addr_q + ADDR_WIDTH'(1);
          end else begin
            wen_q   <= 1'b0;
            wdata_q <= '0;
            if (last_pix) begin
              addr_q  <= '0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              ren_q   <= 1'b1;
              state_q <= StRd;
              // Next pixel base by accumulation: skip row padding at row end.
              if (row_end) begin
                x_q        <= '0;
                y_q        <= y_q + YW'(1);
                row_base_q <= row_base_q + StrideAddr;
                pix_base_q <= row_base_q + StrideAddr;
                addr_q     <= row_base_q + StrideAddr;
              end else begin
                x_q        <= x_q + XW'(1);
                pix_base_q <= pix_base_q + ChAddr;
                addr_q     <= pix_base_q + ChAddr;
              end
            end
          end
        end

        StDone: begin
          done_q <= 1'b1;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
